// File: rtl/axis_fifo_pkg.sv
// Shared definitions for the per-lane AXI-Stream FIFO: width helpers and the
// lane payload layout. The payload struct depends on module parameters, so it
// is provided as a struct-building macro that each user expands with its own
// widths. Payload field order is tdata, tstrb, tkeep, tlast, tid, tdest, tuser.
package axis_fifo_pkg;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Total bits of one stored beat (all payload and sideband fields).
    function automatic int payload_width(input int dw, input int iw, input int dsw, input int uw);
        return dw + 2 * (dw / 8) + 1 + iw + dsw + uw;
    endfunction

endpackage

`ifndef AXIS_FIFO_PAYLOAD_T
`define AXIS_FIFO_PAYLOAD_T(DW, IW, DSW, UW) \
    struct packed { \
        logic [(DW)-1:0]   tdata; \
        logic [(DW)/8-1:0] tstrb; \
        logic [(DW)/8-1:0] tkeep; \
        logic              tlast; \
        logic [(IW)-1:0]   tid; \
        logic [(DSW)-1:0]  tdest; \
        logic [(UW)-1:0]   tuser; \
    }
`endif

// File: rtl/axis_if.sv
// Multi-lane AXI-Stream bundle. Every signal is a flat vector with lane k in
// slice k of the per-lane width.
interface axis #(
    parameter int CHANNEL    = 1,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    localparam int SW = DATA_WIDTH / 8;

    logic [CHANNEL-1:0]            tvalid;
    logic [CHANNEL-1:0]            tready;
    logic [CHANNEL*DATA_WIDTH-1:0] tdata;
    logic [CHANNEL*SW-1:0]         tstrb;
    logic [CHANNEL*SW-1:0]         tkeep;
    logic [CHANNEL-1:0]            tlast;
    logic [CHANNEL*ID_WIDTH-1:0]   tid;
    logic [CHANNEL*DEST_WIDTH-1:0] tdest;
    logic [CHANNEL*USER_WIDTH-1:0] tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_fifo_lane.sv
// One first-word-fall-through FIFO lane. Storage is an array read through a
// registered port addressed by the next read pointer, with a write-forward
// path so a beat written into an empty (or emptying) FIFO appears one cycle
// later. Optional packet mode (macro AXIS_CHAN_FIFO_PKT_MODE_EN) holds output
// valid until a complete packet is stored, or the lane is full.
module axis_fifo_lane
    import axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 16,
    localparam int PW = payload_width(DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH),
    localparam int LW = level_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic [PW-1:0] s_data,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [PW-1:0] m_data,
    output logic [LW-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0] level_reg, level_next;
    logic          ready_reg;
    logic [PW-1:0] out_reg;
    logic          push, pop;

    assign push     = s_tvalid & ready_reg;
    assign pop      = m_tvalid & m_tready;
    assign s_tready = ready_reg;
    assign m_data   = out_reg;
    assign level    = level_reg;

    // Next read address and next occupancy from this cycle's handshakes.
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (pop)
            rd_ptr_next = rd_ptr_reg + AW'(1);
        if (push && !pop)
            level_next = level_reg + LW'(1);
        else if (pop && !push)
            level_next = level_reg - LW'(1);
    end

    // Pointers, occupancy and the registered input-ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            ready_reg  <= (level_next < LW'(DEPTH));
        end
    end

    // Storage write and registered head read; forward the incoming beat when
    // it lands exactly on the entry that becomes the new head.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= s_data;
        if (push && (wr_ptr_reg == rd_ptr_next))
            out_reg <= s_data;
        else
            out_reg <= mem[rd_ptr_next];
    end

`ifdef AXIS_CHAN_FIFO_PKT_MODE_EN
    typedef `AXIS_FIFO_PAYLOAD_T(DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH) payload_t;

    payload_t      s_view, m_view;
    logic [LW-1:0] pkt_cnt_reg;

    assign s_view = s_data;
    assign m_view = out_reg;

    // Count complete packets held; a full lane releases beats regardless so
    // packets longer than the FIFO still drain.
    assign m_tvalid = (level_reg != '0) &&
                      ((pkt_cnt_reg != '0) || (level_reg == LW'(DEPTH)));

    // Packet counter: +1 on pushing a tlast beat, -1 on popping one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pkt_cnt_reg <= '0;
        else if ((push && s_view.tlast) && !(pop && m_view.tlast))
            pkt_cnt_reg <= pkt_cnt_reg + LW'(1);
        else if (!(push && s_view.tlast) && (pop && m_view.tlast))
            pkt_cnt_reg <= pkt_cnt_reg - LW'(1);
    end
`else
    assign m_tvalid = (level_reg != '0);
`endif

endmodule

// File: rtl/axis_chan_fifo.sv
// CHANNEL independent AXI-Stream FIFOs behind one multi-lane interface pair.
// Each lane is a separate axis_fifo_lane, so back-pressure never couples
// lanes. Optional packet mode is selected with macro AXIS_CHAN_FIFO_PKT_MODE_EN.
module axis_chan_fifo
    import axis_fifo_pkg::*;
#(
    parameter int CHANNEL    = 1,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 16,
    localparam int LW = level_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    axis.slave                    s_axis,
    axis.master                   m_axis,
    output logic [CHANNEL*LW-1:0] level
);
    localparam int SW = DATA_WIDTH / 8;

    typedef `AXIS_FIFO_PAYLOAD_T(DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH) payload_t;

    for (genvar gi = 0; gi < CHANNEL; gi++) begin : g_lane
        payload_t s_pl, m_pl;

        assign s_pl.tdata = s_axis.tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign s_pl.tstrb = s_axis.tstrb[gi*SW +: SW];
        assign s_pl.tkeep = s_axis.tkeep[gi*SW +: SW];
        assign s_pl.tlast = s_axis.tlast[gi];
        assign s_pl.tid   = s_axis.tid[gi*ID_WIDTH +: ID_WIDTH];
        assign s_pl.tdest = s_axis.tdest[gi*DEST_WIDTH +: DEST_WIDTH];
        assign s_pl.tuser = s_axis.tuser[gi*USER_WIDTH +: USER_WIDTH];

        axis_fifo_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ID_WIDTH   (ID_WIDTH),
            .DEST_WIDTH (DEST_WIDTH),
            .USER_WIDTH (USER_WIDTH),
            .DEPTH      (DEPTH)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .s_tvalid (s_axis.tvalid[gi]),
            .s_tready (s_axis.tready[gi]),
            .s_data   (s_pl),
            .m_tvalid (m_axis.tvalid[gi]),
            .m_tready (m_axis.tready[gi]),
            .m_data   (m_pl),
            .level    (level[gi*LW +: LW])
        );

        assign m_axis.tdata[gi*DATA_WIDTH +: DATA_WIDTH] = m_pl.tdata;
        assign m_axis.tstrb[gi*SW +: SW]                 = m_pl.tstrb;
        assign m_axis.tkeep[gi*SW +: SW]                 = m_pl.tkeep;
        assign m_axis.tlast[gi]                          = m_pl.tlast;
        assign m_axis.tid[gi*ID_WIDTH +: ID_WIDTH]       = m_pl.tid;
        assign m_axis.tdest[gi*DEST_WIDTH +: DEST_WIDTH] = m_pl.tdest;
        assign m_axis.tuser[gi*USER_WIDTH +: USER_WIDTH] = m_pl.tuser;
    end

endmodule
